tm1638_keys: RTL and testbench

- Periodic key-scan reader for the TM1638 board. It shares the STB/CLK/DIO bus with the display write path (spi_fifo) through a request/grant handshake.
- When granted, it issues the TM1638 read-key command 0x42, turns DIO around, clocks in the 4 key bytes and decodes 8 buttons.
- Its outputs feed the button-driven stimulus selection in the top module, replacing the debounced single button.

---
 rtl/tm1638_keys.sv | 150 +++++++++++++++
 tb/tb_tm1638_keys.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/tm1638_keys.sv
// rtl/tm1638_keys.sv - TM1638 periodic key-scan reader sharing the display SPI bus
module tm1638_keys #(
  parameter int SPI_CYCLES  = 200,
  parameter int WAIT_CYCLES = 54,
  parameter int POLL_CYCLES = 270_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_Bus_Req,
  input  logic       i_Bus_Grant,
  output logic       o_SPI_Stb,
  output logic       o_SPI_Clk,
  output logic       o_SPI_Dio,
  output logic       o_SPI_Dio_Oe,
  input  logic       i_SPI_Dio,
  output logic [7:0] o_Keys,
  output logic       o_Keys_Valid,
  output logic       o_Keys_Changed
);

  localparam int PW   = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int CMAX = (SPI_CYCLES > WAIT_CYCLES) ? SPI_CYCLES : WAIT_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [7:0] CMD_READ_KEYS = 8'h42;

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_CMD, S_WAIT, S_READ, S_DONE} state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] cnt;
  logic          half;      // 0 = SPI clock low phase, 1 = high phase
  logic [4:0]    bit_idx;
  logic [31:0]   sr;
  logic [31:0]   sr_shift;
  logic [7:0]    keys_new;
  logic          poll_end;
  logic          phase_end;
  logic          wait_end;
  logic          bit_end;
  logic          sample;

  // Button i lives in bit 0 of byte i, button i+4 in bit 4 of byte i
  function automatic logic [7:0] decode(input logic [31:0] b);
    decode = {b[28], b[20], b[12], b[4], b[24], b[16], b[8], b[0]};
  endfunction

  assign poll_end  = (poll_cnt == PW'(POLL_CYCLES - 1));
  assign phase_end = (cnt == CW'(SPI_CYCLES - 1));
  assign wait_end  = (cnt == CW'(WAIT_CYCLES - 1));
  assign bit_end   = half && phase_end;
  // Read bit is captured at the end of the first cycle that SPI clock is high
  assign sample    = (state == S_READ) && half && (cnt == '0);
  assign sr_shift  = sample ? {i_SPI_Dio, sr[31:1]} : sr;
  assign keys_new  = decode(sr_shift);

  // State register
  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic; losing the grant mid-transfer abandons the scan
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (poll_end) state_next = S_REQ;
      S_REQ:  if (i_Bus_Grant) state_next = S_CMD;
      S_CMD: begin
        if (!i_Bus_Grant)                  state_next = S_IDLE;
        else if (bit_end && bit_idx == 5'd7) state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!i_Bus_Grant)  state_next = S_IDLE;
        else if (wait_end) state_next = S_READ;
      end
      S_READ: begin
        if (!i_Bus_Grant)                    state_next = S_IDLE;
        else if (bit_end && bit_idx == 5'd31) state_next = S_DONE;
      end
      S_DONE: if (phase_end) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Bus outputs decoded from state and bit position
  always_comb begin
    o_Bus_Req    = (state != S_IDLE);
    o_SPI_Stb    = 1'b1;
    o_SPI_Clk    = 1'b1;
    o_SPI_Dio    = 1'b1;
    o_SPI_Dio_Oe = 1'b0;
    case (state)
      S_CMD: begin
        o_SPI_Stb    = 1'b0;
        o_SPI_Clk    = half;
        o_SPI_Dio    = CMD_READ_KEYS[bit_idx[2:0]];
        o_SPI_Dio_Oe = 1'b1;
      end
      S_WAIT: o_SPI_Stb = 1'b0;
      S_READ: begin
        o_SPI_Stb = 1'b0;
        o_SPI_Clk = half;
      end
      default: ;
    endcase
  end

  // Poll timer, phase/bit counters, read shifter and key decode
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      poll_cnt       <= '0;
      cnt            <= '0;
      half           <= 1'b0;
      bit_idx        <= '0;
      sr             <= '0;
      o_Keys         <= '0;
      o_Keys_Valid   <= 1'b0;
      o_Keys_Changed <= 1'b0;
    end else begin
      o_Keys_Valid   <= 1'b0;
      o_Keys_Changed <= 1'b0;
      poll_cnt       <= (state == S_IDLE && !poll_end) ? poll_cnt + 1'b1 : '0;
      sr             <= sr_shift;
      if (state_next != state) begin
        cnt     <= '0;
        half    <= 1'b0;
        bit_idx <= '0;
      end else if (state == S_CMD || state == S_READ) begin
        if (phase_end) begin
          cnt  <= '0;
          half <= ~half;
          if (half) bit_idx <= bit_idx + 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else if (state == S_WAIT || state == S_DONE) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (state == S_READ && state_next == S_DONE) begin
        o_Keys         <= keys_new;
        o_Keys_Valid   <= 1'b1;
        o_Keys_Changed <= (keys_new != o_Keys);
      end
    end
  end

endmodule

// File: tb/tb_tm1638_keys.sv
// tb/tb_tm1638_keys.sv - directed self-checking bench for tm1638_keys
module tb_tm1638_keys;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst3 = 1'b1;
  logic       grant_en = 1'b1;
  logic       grant_force = 1'b0;
  logic       grant;
  logic       req, stb, sclk, dio_o, oe, valid, changed;
  logic       dio_i = 1'b1;
  logic [7:0] keys;
  logic       req3, stb3, sclk3, dio3_o, oe3, valid3, changed3;
  logic       dio3_i = 1'b1;
  logic [7:0] keys3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign grant = (req & grant_en) | grant_force;

  tm1638_keys #(.SPI_CYCLES(1), .WAIT_CYCLES(2), .POLL_CYCLES(8)) dut (
    .i_Clk(clk), .i_Rst(rst), .o_Bus_Req(req), .i_Bus_Grant(grant),
    .o_SPI_Stb(stb), .o_SPI_Clk(sclk), .o_SPI_Dio(dio_o), .o_SPI_Dio_Oe(oe),
    .i_SPI_Dio(dio_i), .o_Keys(keys), .o_Keys_Valid(valid), .o_Keys_Changed(changed)
  );

  tm1638_keys #(.SPI_CYCLES(3), .WAIT_CYCLES(2), .POLL_CYCLES(8)) dut3 (
    .i_Clk(clk), .i_Rst(rst3), .o_Bus_Req(req3), .i_Bus_Grant(req3),
    .o_SPI_Stb(stb3), .o_SPI_Clk(sclk3), .o_SPI_Dio(dio3_o), .o_SPI_Dio_Oe(oe3),
    .i_SPI_Dio(dio3_i), .o_Keys(keys3), .o_Keys_Valid(valid3), .o_Keys_Changed(changed3)
  );

  // Bus model for dut: correct key bit only during the first high SPI cycle
  logic [31:0] bus_data = 32'h0010_0001;
  logic [7:0]  cmd_sr = 8'h00;
  logic        p_stb = 1'b1, p_clk = 1'b1, last = 1'b0;
  int rd_n = 0, cmd_n = 0, pulses = 0, wait_cyc = 0, vcnt = 0, idle_bad = 0;
  always @(negedge clk) begin
    if (!stb && p_stb) begin rd_n = 0; cmd_n = 0; pulses = 0; wait_cyc = 0; end
    if (!stb && sclk && !p_clk) begin
      pulses++;
      if (oe) begin cmd_sr = {dio_o, cmd_sr[7:1]}; cmd_n++; end
      else if (rd_n < 32) begin last = bus_data[rd_n]; rd_n++; end
    end
    if (!stb && !oe && sclk && rd_n == 0) wait_cyc++;
    dio_i = (!stb && !oe && sclk && !p_clk) ? last : ~last;
    if (valid) vcnt++;
    if (!req && (!stb || !sclk || oe)) idle_bad++;
    p_stb = stb;
    p_clk = sclk;
  end

  // Bus model for dut3 plus SPI phase-length tracking
  logic [31:0] bus_data3 = 32'h0010_0001;
  logic        p_stb3 = 1'b1, p_clk3 = 1'b1, last3 = 1'b0;
  int rd3 = 0, pulses3 = 0, ph3 = 0, bad3 = 0, run3 = 0;
  always @(negedge clk) begin
    if (!stb3 && p_stb3) begin rd3 = 0; pulses3 = 0; ph3 = 0; bad3 = 0; end
    if (!stb3 && sclk3 && !p_clk3) begin
      pulses3++;
      ph3++;
      if (run3 != 3) bad3++;
      if (!oe3 && rd3 < 32) begin last3 = bus_data3[rd3]; rd3++; end
    end
    if (!stb3 && !sclk3 && p_clk3 && rd3 > 0) begin
      ph3++;
      if (run3 != 3) bad3++;
    end
    dio3_i = (!stb3 && !oe3 && sclk3 && !p_clk3) ? last3 : ~last3;
    run3 = (sclk3 != p_clk3) ? 1 : run3 + 1;
    p_stb3 = stb3;
    p_clk3 = sclk3;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(output int n);
    n = 0;
    while (!req && n < 300) begin step(1); n++; end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 300) begin step(1); n++; end
  endtask

  int n, bad, vc;

  initial begin
    // SPI_CYCLES=3 instance: phase lengths, 40 pulses, first-high-cycle sampling
    step(2);
    rst3 = 1'b0;
    n = 0;
    while (!valid3 && n < 400) begin step(1); n++; end
    check("spi3_scan_len", n, 251);
    check("spi3_pulses", pulses3, 40);
    check("spi3_phase_count", ph3, 71);
    check("spi3_phase_bad", bad3, 0);
    check("spi3_keys", keys3, 8'h41);

    // Reset state of main instance
    check("reset_outputs", {req, stb, sclk, dio_o, oe, keys, valid, changed},
          {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    rst = 1'b0;

    // Scan 1: B0..B3 = 01,00,10,00
    wait_req(n);
    check("first_req_delay", n, 8);
    step(1);
    check("cmd_entry_stb_oe", {stb, oe}, 2'b01);
    wait_valid(n);
    check("scan1_len", n, 82);
    check("scan1_keys", keys, 8'h41);
    check("scan1_changed", changed, 1);
    check("cmd_byte", cmd_sr, 8'h42);
    check("cmd_bits", cmd_n, 8);
    check("wait_cycles", wait_cyc, 2);
    check("scan1_pulses", pulses, 40);
    step(1);
    check("valid_one_cycle", {valid, changed, req}, 3'b000);

    // Scan 2: same data, no change
    wait_req(n);
    check("poll_restart", n, 8);
    wait_valid(n);
    check("scan2_len", n, 83);
    check("scan2_keys_changed", {keys, changed}, {8'h41, 1'b0});
    step(1);

    // Scan 3: all ones
    bus_data = 32'hFFFF_FFFF;
    wait_req(n);
    wait_valid(n);
    check("scan3_keys_changed", {keys, changed}, {8'hFF, 1'b1});
    step(1);

    // Scan 4: grant delayed 5 cycles
    grant_en = 1'b0;
    wait_req(n);
    bad = 0;
    repeat (5) begin
      step(1);
      if (!(req && stb && sclk)) bad++;
    end
    check("delayed_grant_hold", bad, 0);
    grant_en = 1'b1;
    wait_valid(n);
    check("delayed_scan_len", n, 83);
    check("delayed_keys_changed", {keys, changed, cmd_sr}, {8'hFF, 1'b0, 8'h42});
    step(1);

    // Scan 5: grant dropped at READ bit 10
    bus_data = 32'h0000_0000;
    wait_req(n);
    step(39);
    check("abort_in_read_bit10", {stb, oe, sclk, rd_n[7:0]}, {3'b000, 8'd10});
    grant_en = 1'b0;
    vc = vcnt;
    step(1);
    check("abort_outputs", {req, stb, sclk, oe}, 4'b0110);
    check("abort_keys_kept", keys, 8'hFF);
    grant_en = 1'b1;
    wait_req(n);
    check("abort_poll_restart", n, 8);
    check("abort_no_valid", vcnt, vc);
    wait_valid(n);
    check("after_abort_scan", {n[7:0], keys, changed}, {8'd83, 8'h00, 1'b1});
    step(1);

    // Scan 6: reset during CMD bit 3, stray grant while idle
    bus_data = 32'h0010_0001;
    wait_req(n);
    step(7);
    check("in_cmd_bit3", {stb, oe, sclk, dio_o}, 4'b0100);
    rst = 1'b1;
    step(1);
    check("midreset_outputs", {req, stb, sclk, dio_o, oe, keys, valid, changed},
          {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    rst = 1'b0;
    grant_force = 1'b1;
    wait_req(n);
    check("req_after_reset", n, 8);
    grant_force = 1'b0;
    wait_valid(n);
    check("post_reset_scan", {n[7:0], keys, changed}, {8'd83, 8'h41, 1'b1});
    check("idle_bus_quiet", idle_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
